kmeans_chan_mux: RTL and testbench
==================================

# kmeans_chan_mux

Registered, handshaked N-channel data selector for the K-means datapath; successor to the fixed 3-way 16-bit combinational selector. Routes one of `NCH` valid/ready input channels of `WIDTH` bits to a single registered output, chosen either by an explicit `sel` or by a round-robin scan. It sits between the per-centroid/per-point producers and the shared distance/accumulate stage, providing backpressure so no sample is dropped or duplicated.

## Interface
Parameters:
- `WIDTH`, 16, data width per channel.
- `NCH`, 3, number of input channels (2..16).
- `SELW`, `$clog2(NCH)`, select/channel-index width (derived; do not override).

Ports:
- `clk`  in  1  rising-edge clock; the block uses this one clock only.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_data`  in  NCH*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- `in_valid`  in  NCH  per-channel valid.
- `in_ready`  out  NCH  per-channel ready; at most one bit high per cycle (combinational).
- `sel`  in  SELW  channel select in fixed mode.
- `mode`  in  1  0 = fixed (`sel`), 1 = round-robin.
- `out_data`  out  WIDTH  registered selected data.
- `out_ch`  out  SELW  index of the channel that produced `out_data`.
- `out_valid`  out  1  output holds a sample.
- `out_ready`  in  1  downstream accepts.
- `err_sel`  out  1  registered one-cycle flag: `sel` >= NCH in fixed mode.

## Operation
- `load` = !out_valid | out_ready. Arbitration occurs only when `load` = 1; otherwise all `in_ready` = 0.
- Fixed mode: grant = `sel` if `sel` < NCH; `in_ready[sel]` = `load`. Transfer on `in_valid[sel]` & `in_ready[sel]`.
- Out-of-range `sel` (>= NCH): no grant, all `in_ready` = 0, nothing loaded; `err_sel` = 1 on the next cycle, otherwise 0. The output register is unaffected, so it keeps draining normally.
- Round-robin mode: pointer `ptr` (SELW bits, 0..NCH-1). Grant = first i with `in_valid[i]` = 1 scanning ptr, ptr+1, …, NCH-1, 0, …, ptr-1. On transfer, `ptr` = granted+1, wrapping NCH-1 -> 0. No valid inputs: no grant, `ptr` holds.
- On transfer: `out_data` <= granted channel data, `out_ch` <= granted index, `out_valid` <= 1.
- No transfer and `out_ready` & `out_valid`: `out_valid` <= 0, and `out_data`/`out_ch` hold their last values.
- `out_valid` & !`out_ready`: `out_data` and `out_ch` are stable and `in_ready` is all zero.
- Simultaneous drain and load (`out_valid` & `out_ready` & transfer): new sample replaces old in the same edge, so the stream runs at full throughput of 1 sample/cycle.
- `mode` change: takes effect on the next arbitration cycle; `ptr` is neither reset nor changed by fixed-mode transfers.
- `in_valid` of non-granted channels is ignored; there is no requirement that producers hold data stable before grant.

## Timing
- Latency: input transfer at edge N -> `out_valid`/`out_data` visible after edge N, so 1 cycle.
- `in_ready` is combinational from `out_valid`, `out_ready`, `mode`, `sel`, `ptr`, and (RR) `in_valid`. It does not depend on `in_data`.
- Reset (async assert, release synchronous to `clk` by system): `out_valid`=0, `out_data`=0, `out_ch`=0, `err_sel`=0, `ptr`=0. While `rst` is high, `in_ready`=0.
- Reset mid-stream: any held sample is discarded; there is no partial output.

## Configuration
- `KMEANS_MUX_RR_EN` defined: round-robin logic and `ptr` are built, and `mode` behaves as above.
- Not defined: `mode` is ignored (fixed mode only), no `ptr` register is built, and round-robin behaviour is absent. All other behaviour is identical.

## Test plan
- Reset: assert `rst` mid-transfer with `out_valid`=1 -> `out_valid`=0, `out_data`=0, `out_ch`=0, `err_sel`=0, and all `in_ready`=0 while in reset.
- Fixed mode, WIDTH=16, NCH=3, `sel`=1, ch1 data 0xBEEF valid, `out_ready`=1 -> next cycle `out_data`=0xBEEF, `out_ch`=1, and only `in_ready[1]` was high.
- Fixed mode, `sel`=3 (NCH=3) -> all `in_ready`=0, `err_sel`=1 one cycle later, and the output register is unchanged apart from draining.
- Backpressure: `out_valid`=1, `out_ready`=0 for 4 cycles with new inputs valid -> `out_data`/`out_ch` stable and `in_ready`=0. Release -> next sample loads on the same edge as the drain.
- Round-robin, all 3 channels valid continuously, `out_ready`=1 -> `out_ch` sequence 0,1,2,0,1,2 at one sample per cycle. With only ch2 and ch0 valid from `ptr`=1 -> order 2,0,2.
- Build without `KMEANS_MUX_RR_EN`, `mode`=1, `sel`=2 -> behaves as fixed mode, selecting ch2 only.

Source files
------------

// File: rtl/kmeans_chan_mux.sv
// kmeans_chan_mux: registered valid/ready N-to-1 channel selector for the K-means datapath.
// Round-robin arbitration and its pointer are built only when KMEANS_MUX_RR_EN is defined.
module kmeans_chan_mux #(
   parameter int WIDTH = 16,
   parameter int NCH   = 3,
   parameter int SELW  = $clog2(NCH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH*WIDTH-1:0]   in_data,
   input  logic [NCH-1:0]         in_valid,
   output logic [NCH-1:0]         in_ready,
   input  logic [SELW-1:0]        sel,
   input  logic                   mode,
   output logic [WIDTH-1:0]       out_data,
   output logic [SELW-1:0]        out_ch,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   err_sel
);

   logic             load;
   logic             sel_ok;
   logic             rr_on;
   logic             rr_gnt;
   logic [SELW-1:0]  rr_idx;
   logic [SELW-1:0]  gnt;
   logic             gnt_vld;
   logic             xfer;
   logic [WIDTH-1:0] gnt_data;

   assign load   = !out_valid || out_ready;
   assign sel_ok = 32'(sel) < NCH;

`ifdef KMEANS_MUX_RR_EN
   logic [SELW-1:0]  ptr;
   logic [2*NCH-1:0] vv;
   logic [NCH-1:0]   rot;

   assign rr_on = mode;
   assign vv    = {in_valid, in_valid};
   assign rot   = vv[{1'b0, ptr} +: NCH];

   // first valid channel at or after ptr, wrapping
   always_comb begin
      int j;
      j      = 0;
      rr_gnt = 1'b0;
      rr_idx = '0;
      for (int k = 0; k < NCH; k++) begin
         if (!rr_gnt && rot[k]) begin
            j = int'(ptr) + k;
            if (j >= NCH) j = j - NCH;
            rr_gnt = 1'b1;
            rr_idx = SELW'(j);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (xfer && rr_on) begin
         if (32'(gnt) == NCH - 1) ptr <= '0;
         else                     ptr <= gnt + 1'b1;
      end
   end
`else
   logic unused_mode;

   assign unused_mode = mode;
   assign rr_on       = 1'b0;
   assign rr_gnt      = 1'b0;
   assign rr_idx      = '0;
`endif

   assign gnt     = rr_on ? rr_idx : sel;
   assign gnt_vld = !rst && load && (rr_on ? rr_gnt : sel_ok);

   always_comb begin
      in_ready = '0;
      gnt_data = '0;
      xfer     = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (gnt == SELW'(i)) begin
            in_ready[i] = gnt_vld;
            gnt_data    = in_data[i*WIDTH +: WIDTH];
            xfer        = gnt_vld && in_valid[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         err_sel   <= 1'b0;
      end else begin
         err_sel <= !rr_on && !sel_ok;
         // a load and a drain on the same edge just overwrite
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_ch    <= gnt;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_kmeans_chan_mux.sv
// Self-checking bench for kmeans_chan_mux (NCH=3, WIDTH=16).
// Cycle model checked every negedge plus hand-computed directed expectations.
module tb_kmeans_chan_mux;

   localparam int W = 16;
   localparam int N = 3;
   localparam int SW = 2;
`ifdef KMEANS_MUX_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N*W-1:0]  in_data = '0;
   logic [N-1:0]    in_valid = '0;
   logic [N-1:0]    in_ready;
   logic [SW-1:0]   sel = '0;
   logic            mode = 1'b0;
   logic [W-1:0]    out_data;
   logic [SW-1:0]   out_ch;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic            err_sel;

   int n_chk = 0;
   int n_pass = 0;

   kmeans_chan_mux #(.WIDTH(W), .NCH(N)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .mode(mode),
      .out_data(out_data), .out_ch(out_ch),
      .out_valid(out_valid), .out_ready(out_ready),
      .err_sel(err_sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // behavioural model: state after each edge, checked mid-cycle
   bit          m_ov = 0;
   logic [W-1:0] m_data = '0;
   int          m_ch = 0;
   bit          m_err = 0;
   int          m_ptr = 0;

   always @(negedge clk) begin
      int g;
      bit rr;
      logic [N-1:0] er;
      if (rst) begin
         m_ov = 0; m_data = '0; m_ch = 0; m_err = 0; m_ptr = 0;
      end
      chk("m_out_valid", 32'(out_valid), 32'(m_ov));
      chk("m_err_sel", 32'(err_sel), 32'(m_err));
      if (m_ov) begin
         chk("m_out_data", 32'(out_data), 32'(m_data));
         chk("m_out_ch", 32'(out_ch), 32'(m_ch));
      end
      rr = RR_EN && mode;
      g = -1;
      if (!rst && (!m_ov || out_ready)) begin
         if (rr) begin
            for (int k = 0; k < N; k++) begin
               if (in_valid[(m_ptr + k) % N]) begin
                  g = (m_ptr + k) % N;
                  break;
               end
            end
         end else if (int'(sel) < N) begin
            g = int'(sel);
         end
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("m_in_ready", 32'(in_ready), 32'(er));
      if (!rst) begin
         m_err = !rr && int'(sel) >= N;
         if (g >= 0 && in_valid[g]) begin
            m_ov = 1;
            m_data = in_data[g*W +: W];
            m_ch = g;
            if (rr) m_ptr = (g + 1) % N;
         end else if (out_ready) begin
            m_ov = 0;
         end
      end
   end

   initial begin
      cyc();
      cyc();
      rst = 1'b0;

      // fixed sel=1, other channels valid but ignored
      in_data = {16'h2222, 16'hBEEF, 16'h1111};
      in_valid = 3'b111;
      sel = 2'd1;
      out_ready = 1'b1;
      #1 chk("fix_rdy", 32'(in_ready), 32'h2);
      cyc();
      chk("fix_data", 32'(out_data), 32'hBEEF);
      chk("fix_ch", 32'(out_ch), 32'd1);
      chk("fix_valid", 32'(out_valid), 32'd1);

      // out-of-range select drains, flags, loads nothing
      sel = 2'd3;
      #1 chk("bad_rdy", 32'(in_ready), 32'h0);
      cyc();
      chk("bad_err", 32'(err_sel), 32'd1);
      chk("bad_valid", 32'(out_valid), 32'd0);
      chk("bad_hold", 32'(out_data), 32'hBEEF);
      sel = 2'd0;
      cyc();
      chk("err_clr", 32'(err_sel), 32'd0);
      chk("sel0_data", 32'(out_data), 32'h1111);

      // backpressure for 4 cycles with fresh inputs
      out_ready = 1'b0;
      sel = 2'd2;
      for (int i = 0; i < 4; i++) begin
         in_data[2*W +: W] = 16'hC000 + 16'(i);
         #1;
         chk("bp_rdy", 32'(in_ready), 32'h0);
         chk("bp_data", 32'(out_data), 32'h1111);
         chk("bp_ch", 32'(out_ch), 32'd0);
         cyc();
      end
      out_ready = 1'b1;
      in_data[2*W +: W] = 16'hCAFE;
      #1 chk("rel_rdy", 32'(in_ready), 32'h4);
      cyc();
      chk("rel_data", 32'(out_data), 32'hCAFE);
      chk("rel_ch", 32'(out_ch), 32'd2);
      chk("rel_valid", 32'(out_valid), 32'd1);

      // reset with a held sample
      out_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_ch", 32'(out_ch), 32'd0);
      chk("rst_err", 32'(err_sel), 32'd0);
      chk("rst_rdy", 32'(in_ready), 32'h0);
      cyc();
      rst = 1'b0;
      out_ready = 1'b1;

`ifdef KMEANS_MUX_RR_EN
      mode = 1'b1;
      in_data = {16'hA002, 16'hA001, 16'hA000};
      in_valid = 3'b111;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("rr_all_ch", 32'(out_ch), 32'(i % 3));
         chk("rr_all_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 3'b001;
      cyc();
      chk("rr_p1_ch", 32'(out_ch), 32'd0);
      in_valid = 3'b101;
      cyc();
      chk("rr_20_a", 32'(out_ch), 32'd2);
      cyc();
      chk("rr_20_b", 32'(out_ch), 32'd0);
      cyc();
      chk("rr_20_c", 32'(out_ch), 32'd2);
      // fixed transfer must not move ptr (ptr is 0 here)
      mode = 1'b0;
      sel = 2'd1;
      in_valid = 3'b111;
      cyc();
      chk("fix_mid_ch", 32'(out_ch), 32'd1);
      mode = 1'b1;
      cyc();
      chk("rr_after_fix", 32'(out_ch), 32'd0);
      chk("rr_after_data", 32'(out_data), 32'hA000);
`else
      mode = 1'b1;
      sel = 2'd2;
      in_data = {16'h5A5A, 16'h0F0F, 16'hF0F0};
      in_valid = 3'b111;
      #1 chk("norr_rdy", 32'(in_ready), 32'h4);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("norr_ch", 32'(out_ch), 32'd2);
         chk("norr_data", 32'(out_data), 32'h5A5A);
      end
`endif

      // mixed sweep, checked by the model only
      for (int i = 0; i < 60; i++) begin
         in_valid = N'($urandom_range(0, 7));
         out_ready = 1'($urandom_range(0, 3) != 0);
         sel = SW'($urandom_range(0, 3));
         mode = 1'($urandom_range(0, 1));
         in_data = {16'($urandom), 16'($urandom), 16'($urandom)};
         cyc();
      end
      in_valid = '0;
      out_ready = 1'b1;
      cyc();
      cyc();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
